// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO between the UART receiver and the bus
// read path. First-word fall-through head, level/full/empty, sticky overflow
// and a level-type threshold interrupt.
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to add an idle-timeout
// interrupt (timeout_i / intr_timeout_o).
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_en,
    input  logic [WIDTH-1:0] rx_byte_i,
    input  logic             rx_dv_i,
    input  logic             pop_i,
    input  logic             clr_i,
    input  logic             ovf_clr_i,
    input  logic [LW-1:0]    thresh_i,
`ifdef UART_RX_FIFO_TIMEOUT_EN
    input  logic [15:0]      timeout_i,
    output logic             intr_timeout_o,
`endif
    output logic [WIDTH-1:0] rdata_o,
    output logic [LW-1:0]    level_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ovf_o,
    output logic             intr_rx_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_nxt;
    logic             ovf_q;
    logic             intr_rx_q;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             drop;

    // Status decoded from the level counter; pointers alone never decide full/empty
    assign empty_o = (level_q == LW'(0));
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign ovf_o   = ovf_q;
    assign intr_rx_o = intr_rx_q;
    assign rdata_o = empty_o ? WIDTH'(0) : mem_q[rptr_q];

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    assign push  = rx_en & rx_dv_i;
    assign pop   = pop_i & ~empty_o;
    assign wr_en = push & (~full_o | pop);
    assign drop  = push & full_o & ~pop;

    // Next level: clear wins, otherwise +1/-1/hold
    always_comb begin
        level_nxt = level_q;
        if (clr_i) begin
            level_nxt = LW'(0);
        end else begin
            case ({wr_en, pop})
                2'b10:   level_nxt = level_q + LW'(1);
                2'b01:   level_nxt = level_q - LW'(1);
                default: level_nxt = level_q;
            endcase
        end
    end

    // Storage array; not reset and not cleared by clr_i
    always_ff @(posedge clk_i) begin
        if (wr_en && !clr_i) begin
            mem_q[wptr_q] <= rx_byte_i;
        end
    end

    // Pointers, level, sticky overflow and threshold interrupt
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            intr_rx_q <= 1'b0;
        end else begin
            level_q   <= level_nxt;
            intr_rx_q <= (thresh_i != LW'(0)) && (level_nxt >= thresh_i);
            if (clr_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (wr_en) wptr_q <= wptr_q + AW'(1);
                if (pop)   rptr_q <= rptr_q + AW'(1);
                if (drop)           ovf_q <= 1'b1;
                else if (ovf_clr_i) ovf_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [15:0] idle_cnt_q;
    logic [15:0] idle_cnt_nxt;
    logic        intr_to_q;
    logic        activity;

    assign activity       = push | pop | clr_i;
    assign intr_timeout_o = intr_to_q;

    // Idle counter restarts on any FIFO activity or while empty, saturates at max
    always_comb begin
        idle_cnt_nxt = idle_cnt_q;
        if (activity || empty_o) begin
            idle_cnt_nxt = 16'(0);
        end else if (idle_cnt_q != 16'hFFFF) begin
            idle_cnt_nxt = idle_cnt_q + 16'(1);
        end
    end

    // Timeout interrupt holds until the next push, pop or clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_cnt_q <= '0;
            intr_to_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_nxt;
            if (activity) begin
                intr_to_q <= 1'b0;
            end else if ((timeout_i != 16'(0)) && !empty_o && (idle_cnt_nxt == timeout_i)) begin
                intr_to_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (default build, DEPTH=8, WIDTH=8).
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned LW    = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             rx_en;
    logic [WIDTH-1:0] rx_byte_i;
    logic             rx_dv_i;
    logic             pop_i;
    logic             clr_i;
    logic             ovf_clr_i;
    logic [LW-1:0]    thresh_i;
    logic [WIDTH-1:0] rdata_o;
    logic [LW-1:0]    level_o;
    logic             empty_o;
    logic             full_o;
    logic             ovf_o;
    logic             intr_rx_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] sb[$];
    logic       m_ovf;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rx_en     (rx_en),
        .rx_byte_i (rx_byte_i),
        .rx_dv_i   (rx_dv_i),
        .pop_i     (pop_i),
        .clr_i     (clr_i),
        .ovf_clr_i (ovf_clr_i),
        .thresh_i  (thresh_i),
        .rdata_o   (rdata_o),
        .level_o   (level_o),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .ovf_o     (ovf_o),
        .intr_rx_o (intr_rx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every status output against the scoreboard model
    task automatic check_state(input string tag);
        logic [7:0] head;
        logic       exp_intr;
        head     = (sb.size() != 0) ? sb[0] : 8'h00;
        exp_intr = (thresh_i != 0) && (sb.size() >= int'(thresh_i));
        chk({tag, ".level"}, 32'(level_o),   32'(sb.size()));
        chk({tag, ".empty"}, 32'(empty_o),   32'(sb.size() == 0));
        chk({tag, ".full"},  32'(full_o),    32'(sb.size() == DEPTH));
        chk({tag, ".rdata"}, 32'(rdata_o),   32'(head));
        chk({tag, ".ovf"},   32'(ovf_o),     32'(m_ovf));
        chk({tag, ".intr"},  32'(intr_rx_o), 32'(exp_intr));
    endtask

    // One clock of stimulus: optional strobe, pop and overflow clear
    task automatic step(input logic dv, input logic [7:0] b, input logic pp, input logic ovc);
        logic drop;
        drop      = 1'b0;
        rx_dv_i   = dv;
        rx_byte_i = b;
        pop_i     = pp;
        ovf_clr_i = ovc;
        if (pp && sb.size() != 0) begin
            chk("pop_data", 32'(rdata_o), 32'(sb[0]));
            void'(sb.pop_front());
        end
        if (dv && rx_en) begin
            if (sb.size() < DEPTH) sb.push_back(b);
            else drop = 1'b1;
        end
        if (drop)     m_ovf = 1'b1;
        else if (ovc) m_ovf = 1'b0;
        @(posedge clk_i); #1;
        rx_dv_i   = 1'b0;
        pop_i     = 1'b0;
        ovf_clr_i = 1'b0;
    endtask

    task automatic do_clr(input logic dv, input logic [7:0] b, input logic pp);
        clr_i     = 1'b1;
        rx_dv_i   = dv;
        rx_byte_i = b;
        pop_i     = pp;
        ovf_clr_i = 1'b1;
        sb.delete();
        m_ovf = 1'b0;
        @(posedge clk_i); #1;
        clr_i     = 1'b0;
        rx_dv_i   = 1'b0;
        pop_i     = 1'b0;
        ovf_clr_i = 1'b0;
    endtask

    initial begin
        rst_ni    = 1'b0;
        rx_en     = 1'b1;
        rx_byte_i = '0;
        rx_dv_i   = 1'b0;
        pop_i     = 1'b0;
        clr_i     = 1'b0;
        ovf_clr_i = 1'b0;
        thresh_i  = '0;
        m_ovf     = 1'b0;

        // Reset and idle
        repeat (2) @(posedge clk_i);
        #1;
        check_state("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check_state("idle");

        // Fill 0x11..0x18, then drain in order
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        check_state("filled");
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("drained");

        // Pop while empty has no effect
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("pop_empty");

        // Wrap-around
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        check_state("wrap_full");

        // Overflow: drop 0x55, then clear the flag
        step(1'b1, 8'h55, 1'b0, 1'b0);
        check_state("ovf_drop");
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_state("ovf_clr");

        // Push and pop together while full: no overflow, level stays 8
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check_state("full_push_pop");

        // Drop and overflow clear in the same cycle: set wins
        step(1'b1, 8'h99, 1'b0, 1'b1);
        check_state("drop_vs_clr");
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Drain; 0x55 and 0x99 must not appear
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("wrap_drained");

        // Push and pop together while empty: only the push happens
        step(1'b1, 8'h42, 1'b1, 1'b0);
        check_state("empty_push_pop");
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Strobe with receiver disabled is lost without overflow
        rx_en = 1'b0;
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        check_state("rx_disabled");
        rx_en = 1'b1;

        // Threshold interrupt
        thresh_i = 4'd3;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hC0, 1'b0, 1'b0);
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        check_state("thr_below");
        step(1'b1, 8'hC2, 1'b0, 1'b0);
        check_state("thr_reach");
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("thr_drop");
        thresh_i = 4'd0;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        check_state("thr_zero_full");
        thresh_i = 4'd9;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_state("thr_above_depth");
        thresh_i = 4'd8;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_state("thr_eq_depth");
        thresh_i = 4'd0;

        // Overflow, pop to half, then clear with push and pop also asserted
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check_state("half_ovf");
        do_clr(1'b1, 8'h66, 1'b1);
        check_state("clr");
        step(1'b1, 8'h81, 1'b0, 1'b0);
        check_state("after_clr_push");

        // Asynchronous reset mid-operation, strobe during reset is lost
        thresh_i = 4'd2;
        step(1'b1, 8'h82, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        check_state("pre_rst");
        #2;
        rst_ni = 1'b0;
        #1;
        sb.delete();
        m_ovf = 1'b0;
        check_state("async_rst");
        rx_dv_i   = 1'b1;
        rx_byte_i = 8'hBB;
        @(posedge clk_i); #1;
        rx_dv_i = 1'b0;
        check_state("rst_strobe");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        step(1'b1, 8'hE1, 1'b0, 1'b0);
        check_state("post_rst_push");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
